// File: rtl/traffic_controller_ndir.sv
// Round-robin traffic-signal controller for NUM_DIR approaches: detector-actuated green,
// fixed yellow and all-red clearance, plus a flashing-yellow mode while en is low.
module traffic_controller_ndir #(
  parameter int NUM_DIR     = 2,
  parameter int TW          = 8,
  parameter int GREEN_MIN   = 10,
  parameter int GREEN_MAX   = 30,
  parameter int YELLOW_CYC  = 2,
  parameter int ALL_RED_CYC = 1,
  parameter int FLASH_CYC   = 4,
  parameter int DW          = (NUM_DIR > 2) ? $clog2(NUM_DIR) : 1
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic               en,
  input  logic [NUM_DIR-1:0] detect,
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] green,
  output logic [1:0]         phase,
  output logic [DW-1:0]      cur_dir
);

  localparam longint TMAX = (longint'(1) <<< TW) - longint'(1);

  if (NUM_DIR < 2 || GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN || YELLOW_CYC < 1 ||
      ALL_RED_CYC < 1 || FLASH_CYC < 1 || DW < 1 || DW < $clog2(NUM_DIR) ||
      longint'(GREEN_MAX) > TMAX || longint'(YELLOW_CYC) > TMAX ||
      longint'(ALL_RED_CYC) > TMAX || longint'(FLASH_CYC) > TMAX) begin : g_bad_params
    $error("traffic_controller_ndir: illegal parameter combination");
  end

  // The encoding doubles as the phase output, so phase is a direct view of the FSM.
  typedef enum logic [1:0] {
    ST_ALL_RED = 2'b00,
    ST_GREEN   = 2'b01,
    ST_YELLOW  = 2'b10,
    ST_FLASH   = 2'b11
  } state_t;

  localparam logic [TW-1:0] AR_LOAD    = TW'(ALL_RED_CYC - 1);
  localparam logic [TW-1:0] Y_LOAD     = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] FL_LOAD    = TW'(FLASH_CYC - 1);
  localparam logic [TW-1:0] G_MIN_LAST = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] G_MAX_LAST = TW'(GREEN_MAX - 1);
  localparam logic [DW-1:0] LAST_DIR   = DW'(NUM_DIR - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] dir_q, dir_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] g_cnt_q, g_cnt_d;
  logic          flash_q, flash_d;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= ST_ALL_RED;
      dir_q   <= '0;
      timer_q <= AR_LOAD;
      g_cnt_q <= '0;
      flash_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      g_cnt_q <= g_cnt_d;
      flash_q <= flash_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    g_cnt_d = g_cnt_q;
    flash_d = flash_q;
    if (!en) begin
      // en low wins over every normal transition; inside FLASH it just keeps blinking.
      if (state_q != ST_FLASH) begin
        state_d = ST_FLASH;
        flash_d = 1'b1;
        timer_d = FL_LOAD;
      end else if (timer_q == '0) begin
        flash_d = ~flash_q;
        timer_d = FL_LOAD;
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end else begin
      case (state_q)
        ST_FLASH: begin
          state_d = ST_ALL_RED;
          timer_d = AR_LOAD;
          dir_d   = '0;
        end
        ST_ALL_RED: begin
          if (timer_q == '0) begin
            state_d = ST_GREEN;
            g_cnt_d = '0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        ST_GREEN: begin
          if (g_cnt_q == G_MAX_LAST || (g_cnt_q >= G_MIN_LAST && !detect[dir_q])) begin
            state_d = ST_YELLOW;
            timer_d = Y_LOAD;
          end else begin
            g_cnt_d = g_cnt_q + TW'(1);
          end
        end
        ST_YELLOW: begin
          if (timer_q == '0) begin
            state_d = ST_ALL_RED;
            timer_d = AR_LOAD;
            dir_d   = (dir_q == LAST_DIR) ? '0 : dir_q + DW'(1);
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: state_d = ST_ALL_RED;
      endcase
    end
  end

  always_comb begin
    red    = '0;
    yellow = '0;
    green  = '0;
    case (state_q)
      ST_ALL_RED: red = '1;
      ST_GREEN: begin
        red          = '1;
        red[dir_q]   = 1'b0;
        green[dir_q] = 1'b1;
      end
      ST_YELLOW: begin
        red           = '1;
        red[dir_q]    = 1'b0;
        yellow[dir_q] = 1'b1;
      end
      ST_FLASH: yellow = {NUM_DIR{flash_q}};
      default: red = '1;
    endcase
  end

  assign phase   = state_q;
  assign cur_dir = dir_q;

endmodule

// File: tb/tb_traffic_controller_ndir.sv
// Bench for traffic_controller_ndir: a 2-approach default instance and a 3-approach
// fixed-green instance, checked by directed scenarios and a duration-based reference model.
module tb_traffic_controller_ndir;

  logic       clk;
  logic       res_n;
  logic       en;
  logic [1:0] det2;
  logic [2:0] det3;
  logic [1:0] r2, y2, g2, ph2;
  logic       cd2;
  logic [2:0] r3, y3, g3;
  logic [1:0] ph3, cd3;

  int vectors = 0;
  int miscompares = 0;

  traffic_controller_ndir dut2 (
    .clk(clk), .res_n(res_n), .en(en), .detect(det2),
    .red(r2), .yellow(y2), .green(g2), .phase(ph2), .cur_dir(cd2)
  );

  traffic_controller_ndir #(
    .NUM_DIR(3), .GREEN_MIN(3), .GREEN_MAX(3), .YELLOW_CYC(1), .ALL_RED_CYC(2)
  ) dut3 (
    .clk(clk), .res_n(res_n), .en(en), .detect(det3),
    .red(r3), .yellow(y3), .green(g3), .phase(ph3), .cur_dir(cd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase plus cycles remaining / green cycles elapsed, counted from 1.
  typedef struct {
    int n, gmin, gmax, ycyc, arcyc, fcyc;
    int ph, dir, left, gel;
    bit fl;
  } m_t;

  function automatic m_t m_init(int n, int gmin, int gmax, int ycyc, int arcyc, int fcyc);
    m_t s;
    s.n = n; s.gmin = gmin; s.gmax = gmax; s.ycyc = ycyc; s.arcyc = arcyc; s.fcyc = fcyc;
    s.ph = 0; s.dir = 0; s.left = arcyc; s.gel = 0; s.fl = 1'b1;
    return s;
  endfunction

  function automatic m_t m_step(m_t s, bit en_v, int det);
    m_t t = s;
    if (!en_v) begin
      if (s.ph != 3) begin
        t.ph = 3; t.fl = 1'b1; t.left = s.fcyc;
      end else if (s.left == 1) begin
        t.fl = !s.fl; t.left = s.fcyc;
      end else begin
        t.left = s.left - 1;
      end
    end else begin
      case (s.ph)
        3: begin t.ph = 0; t.left = s.arcyc; t.dir = 0; end
        0: if (s.left == 1) begin t.ph = 1; t.gel = 1; end else t.left = s.left - 1;
        1: if (s.gel == s.gmax || (s.gel >= s.gmin && ((det >> s.dir) & 1) == 0)) begin
             t.ph = 2; t.left = s.ycyc;
           end else t.gel = s.gel + 1;
        default: if (s.left == 1) begin
             t.ph = 0; t.left = s.arcyc; t.dir = (s.dir + 1) % s.n;
           end else t.left = s.left - 1;
      endcase
    end
    return t;
  endfunction

  function automatic int exp_word(m_t s);
    int full, g, y, r;
    full = (1 << s.n) - 1;
    g = 0;
    y = 0;
    if (s.ph == 1) g = 1 << s.dir;
    if (s.ph == 2) y = 1 << s.dir;
    if (s.ph == 3 && s.fl) y = full;
    r = (s.ph == 3) ? 0 : (full & ~(g | y));
    return r | (y << 4) | (g << 8) | (s.ph << 12) | (s.dir << 16);
  endfunction

  function automatic int obs2();
    return int'(r2) | (int'(y2) << 4) | (int'(g2) << 8) | (int'(ph2) << 12) | (int'(cd2) << 16);
  endfunction

  function automatic int obs3();
    return int'(r3) | (int'(y3) << 4) | (int'(g3) << 8) | (int'(ph3) << 12) | (int'(cd3) << 16);
  endfunction

  task automatic apply_reset(input bit en_v);
    @(negedge clk);
    res_n = 1'b0;
    en    = en_v;
    det2  = '0;
    det3  = '0;
    @(negedge clk);
    res_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 res_n = 1'b0;
    #1;
    vectors++;
    if (obs2() !== 32'h00003) begin
      miscompares++;
      $display("FAIL reset_dut2: got %h want %h", obs2(), 32'h00003);
    end
    vectors++;
    if (obs3() !== 32'h00007) begin
      miscompares++;
      $display("FAIL reset_dut3: got %h want %h", obs3(), 32'h00007);
    end
  endtask

  task automatic test_basic_sequence();
    int rc2[$], rl2[$], rc3[$], rl3[$];
    int c;
    int e2c[13] = '{'h00, 'h10, 'h20, 'h01, 'h11, 'h21, 'h00, 'h10, 'h20, 'h01, 'h11, 'h21, 'h00};
    int e2l[13] = '{1, 10, 2, 1, 10, 2, 1, 10, 2, 1, 10, 2, 1};
    int e3c[12] = '{'h00, 'h10, 'h20, 'h01, 'h11, 'h21, 'h02, 'h12, 'h22, 'h00, 'h10, 'h20};
    int e3l[12] = '{2, 3, 1, 2, 3, 1, 2, 3, 1, 2, 3, 1};
    apply_reset(1'b1);
    for (int i = 0; i < 60; i++) begin
      c = int'(ph2) * 16 + int'(cd2);
      if (rc2.size() == 0 || rc2[rc2.size()-1] != c) begin
        rc2.push_back(c); rl2.push_back(1);
      end else rl2[rl2.size()-1] = rl2[rl2.size()-1] + 1;
      c = int'(ph3) * 16 + int'(cd3);
      if (rc3.size() == 0 || rc3[rc3.size()-1] != c) begin
        rc3.push_back(c); rl3.push_back(1);
      end else rl3[rl3.size()-1] = rl3[rl3.size()-1] + 1;
      @(negedge clk);
    end
    for (int k = 0; k < 13; k++) begin
      vectors++;
      if (k >= rc2.size() || rc2[k] != e2c[k] || rl2[k] != e2l[k]) begin
        miscompares++;
        if (k >= rc2.size()) $display("FAIL seq2_run%0d: missing, want phase/dir %h x%0d", k, e2c[k], e2l[k]);
        else $display("FAIL seq2_run%0d: got phase/dir %h x%0d want %h x%0d", k, rc2[k], rl2[k], e2c[k], e2l[k]);
      end
    end
    for (int k = 0; k < 12; k++) begin
      vectors++;
      if (k >= rc3.size() || rc3[k] != e3c[k] || rl3[k] != e3l[k]) begin
        miscompares++;
        if (k >= rc3.size()) $display("FAIL seq3_run%0d: missing, want phase/dir %h x%0d", k, e3c[k], e3l[k]);
        else $display("FAIL seq3_run%0d: got phase/dir %h x%0d want %h x%0d", k, rc3[k], rl3[k], e3c[k], e3l[k]);
      end
    end
  endtask

  task automatic test_green_extend();
    int cnt;
    apply_reset(1'b1);
    det2 = 2'b01;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (g2 == 2'b01) cnt++;
      else if (cnt > 0) break;
      @(negedge clk);
    end
    vectors++;
    if (cnt != 30) begin
      miscompares++;
      $display("FAIL green_max: got %0d cycles want 30", cnt);
    end
    apply_reset(1'b1);
    det2 = 2'b01;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (g2 == 2'b01) begin
        cnt++;
        if (cnt == 15) det2 = 2'b00;
      end else if (cnt > 0) break;
      @(negedge clk);
    end
    vectors++;
    if (cnt != 15 || ph2 !== 2'b10) begin
      miscompares++;
      $display("FAIL green_drop: got %0d cycles then phase %b want 15 then 10", cnt, ph2);
    end
  endtask

  task automatic test_flash();
    bit found;
    logic [7:0] want;
    apply_reset(1'b1);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (g2 == 2'b10) begin found = 1'b1; break; end
      @(negedge clk);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL flash_reach_green1: got no green[1] within 60 cycles want green[1]");
    end
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      want = {2'b11, 2'b00, ((i / 4) % 2 == 0) ? 2'b11 : 2'b00, 2'b00};
      vectors++;
      if ({ph2, r2, y2, g2} !== want) begin
        miscompares++;
        $display("FAIL flash_cycle%0d: got ph/r/y/g %b want %b", i, {ph2, r2, y2, g2}, want);
      end
      @(negedge clk);
    end
    en = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs2() !== 32'h00003) begin
      miscompares++;
      $display("FAIL flash_exit_allred: got %h want %h", obs2(), 32'h00003);
    end
    @(negedge clk);
    vectors++;
    if (obs2() !== 32'h01102) begin
      miscompares++;
      $display("FAIL flash_exit_green0: got %h want %h", obs2(), 32'h01102);
    end
  endtask

  task automatic test_reset_mid_yellow();
    bit found;
    apply_reset(1'b1);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (ph2 == 2'b10 && cd2 == 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL reach_yellow1: got no yellow of dir 1 within 60 cycles want yellow");
    end
    #3 res_n = 1'b0;
    #1;
    vectors++;
    if (obs2() !== 32'h00003) begin
      miscompares++;
      $display("FAIL async_reset: got %h want %h", obs2(), 32'h00003);
    end
    @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs2() !== 32'h01102) begin
      miscompares++;
      $display("FAIL restart_green0: got %h want %h", obs2(), 32'h01102);
    end
  endtask

  task automatic test_en_pulse();
    apply_reset(1'b1);
    en = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs2() !== 32'h03030 || obs3() !== 32'h03070) begin
      miscompares++;
      $display("FAIL pulse_flash: got %h/%h want 03030/03070", obs2(), obs3());
    end
    en = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs2() !== 32'h00003 || obs3() !== 32'h00007) begin
      miscompares++;
      $display("FAIL pulse_allred1: got %h/%h want 00003/00007", obs2(), obs3());
    end
    @(negedge clk);
    vectors++;
    if (obs2() !== 32'h01102 || obs3() !== 32'h00007) begin
      miscompares++;
      $display("FAIL pulse_allred2: got %h/%h want 01102/00007", obs2(), obs3());
    end
    @(negedge clk);
    vectors++;
    if (obs3() !== 32'h01106) begin
      miscompares++;
      $display("FAIL pulse_green0_dut3: got %h want %h", obs3(), 32'h01106);
    end
  endtask

  task automatic test_random();
    m_t m0, m1;
    int d2, d3;
    bit en_v;
    apply_reset(1'b1);
    m0 = m_init(2, 10, 30, 2, 1, 4);
    m1 = m_init(3, 3, 3, 1, 2, 4);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      vectors++;
      if (obs2() !== exp_word(m0)) begin
        miscompares++;
        $display("FAIL rand_dut2 cyc %0d: got %h want %h", cyc, obs2(), exp_word(m0));
      end
      vectors++;
      if (obs3() !== exp_word(m1)) begin
        miscompares++;
        $display("FAIL rand_dut3 cyc %0d: got %h want %h", cyc, obs3(), exp_word(m1));
      end
      if (ph2 != 2'b11) begin
        vectors++;
        if ($countones(~r2) > 1 || (~r2) !== (g2 | y2)) begin
          miscompares++;
          $display("FAIL one_nonred_dut2 cyc %0d: got r/y/g %b/%b/%b want one lit approach", cyc, r2, y2, g2);
        end
      end
      if (ph3 != 2'b11) begin
        vectors++;
        if ($countones(~r3) > 1 || (~r3) !== (g3 | y3)) begin
          miscompares++;
          $display("FAIL one_nonred_dut3 cyc %0d: got r/y/g %b/%b/%b want one lit approach", cyc, r3, y3, g3);
        end
      end
      en_v = ($urandom_range(0, 39) != 0);
      d2 = 0;
      d3 = 0;
      for (int b = 0; b < 2; b++) if ($urandom_range(0, 3) != 0) d2 |= (1 << b);
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 3) != 0) d3 |= (1 << b);
      en   = en_v;
      det2 = d2[1:0];
      det3 = d3[2:0];
      m0 = m_step(m0, en_v, d2);
      m1 = m_step(m1, en_v, d3);
      @(negedge clk);
    end
  endtask

  initial begin
    res_n = 1'b1;
    en    = 1'b1;
    det2  = '0;
    det3  = '0;
    test_reset();
    test_basic_sequence();
    test_green_extend();
    test_flash();
    test_reset_mid_yellow();
    test_en_pulse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
